// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scan controller.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    FINISH
  } scan_state_t;

  // Truth table of the 3-input function block under test.
  localparam logic [7:0] FUN_TRUTH = 8'h39;

  function automatic int tbl_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_gray_enc.sv
// Binary-to-Gray encoder, purely combinational, W bits wide.
module tt_gray_enc #(
  parameter int W = 3
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/tt_scan_ctrl.sv
// Scans all input vectors of a small Boolean block, captures its truth table
// and compares it with EXPECTED. Define TT_SCAN_GRAY_EN to drive vectors in Gray order.
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int                              N_IN     = 3,
  parameter int                              SETTLE   = 1,
  parameter logic [tbl_width(N_IN)-1:0]      EXPECTED = FUN_TRUTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [N_IN-1:0]            vec_out,
  input  logic                       y_in,
  output logic                       busy,
  output logic                       done,
  output logic [tbl_width(N_IN)-1:0] table_out,
  output logic [N_IN:0]              err_cnt,
  output logic [N_IN-1:0]            first_err_idx,
  output logic                       pass
);

  localparam int         TBL_W       = tbl_width(N_IN);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  scan_state_t       r_state;
  scan_state_t       w_next;
  logic [N_IN-1:0]   r_step;
  logic [N_IN-1:0]   w_drive;
  logic [3:0]        r_settle;
  logic              w_last;
  logic              w_miss;
  logic              r_busy;
  logic              r_done;
  logic [TBL_W-1:0]  r_table;
  logic [N_IN:0]     r_err_cnt;
  logic [N_IN-1:0]   r_first_err;
  logic              r_pass;

  // r_step counts scan steps; w_drive is the vector value actually applied.
`ifdef TT_SCAN_GRAY_EN
  tt_gray_enc #(.W(N_IN)) u_gray_enc (
    .i_bin  (r_step),
    .o_gray (w_drive)
  );
`else
  assign w_drive = r_step;
`endif

  assign w_last = (r_step == {N_IN{1'b1}});
  assign w_miss = (y_in != EXPECTED[w_drive]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    vec_out = '0;
    case (r_state)
      IDLE:   if (start) w_next = WAIT;
      WAIT: begin
        vec_out = w_drive;
        if (r_settle == SETTLE_LAST) w_next = SAMPLE;
      end
      SAMPLE: begin
        vec_out = w_drive;
        w_next  = w_last ? FINISH : WAIT;
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step      <= '0;
      r_settle    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_table     <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_step      <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b1;
            r_table     <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
          end
        end
        WAIT: r_settle <= r_settle + 4'd1;
        SAMPLE: begin
          r_table[w_drive] <= y_in;
          if (w_miss) begin
            // A zero count means this is the first mismatch of the scan.
            if (r_err_cnt == '0) r_first_err <= w_drive;
            r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
          end
          if (!w_last) begin
            r_step   <= r_step + N_IN'(1);
            r_settle <= '0;
          end
        end
        FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign table_out     = r_table;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_err;
  assign pass          = r_pass;

endmodule
